id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the ID-stage controller and register file, and feeds the EX stage.
- Latches the controller's control bundle and the decoded operands every cycle.
- Contains load-use and ID-branch hazard detection. On a hazard it inserts a bubble into EX and freezes PC and IF/ID.
- Gates the controller's IF/ID flush during a stall and keeps saturating stall/bubble statistics counters.

Parameters:
DATA_W, 32, width of operand, immediate and PC paths
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous active-high reset
id_opc  in  6  opcode of the instruction in ID
id_RegDst  in  2  controller RegDst: 00 rt, 01 rd, 10 $31
id_RegData  in  2  controller RegData select
id_ALUSrc  in  1  controller ALUSrc
id_MemRead  in  1  controller MemRead
id_MemWrite  in  1  controller MemWrite
id_RegWrite  in  1  controller RegWrite
id_ALUOpc  in  3  ALU operation from the ALU controller
id_IFIDFlush  in  1  controller IF/ID flush request
id_rd1  in  DATA_W  register file read data, rs
id_rd2  in  DATA_W  register file read data, rt
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4 of the ID instruction
id_rs, id_rt, id_rd  in  5 each  register fields
ex_RegData, ex_ALUOpc, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite  out  as inputs  registered control
ex_rd1, ex_rd2, ex_imm, ex_pc4  out  DATA_W  registered data
ex_rs, ex_rt  out  5  registered source fields, for forwarding
ex_dst  out  5  resolved destination register
pc_write  out  1  0 freezes PC
ifid_write  out  1  0 freezes IF/ID
ifid_flush  out  1  gated flush to IF/ID
stall_cnt  out  CNT_W  number of stall cycles
bubble_cnt  out  CNT_W  number of bubbles entered into EX

Behaviour:
- Reset (rst high at a clk edge):
  - All ex_* outputs become 0.
  - Internal MEM shadow (mem_dst, mem_MemRead) becomes 0.
  - Both counters become 0.
  - Reset wins over everything else.
- Source usage, decoded from id_opc:
  - use_rs: R-type 000000, addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, jr 111111.
  - use_rt: R-type, sw, beq.
  - j and jal use neither source.
  - is_br: beq or jr.
- Destination resolution at latch time:
  - RegDst 00 -> id_rt; 01 -> id_rd; 10 -> 5'd31; 11 -> 0.
  - Destination 0 never causes a hazard.
- Hazard, combinational, with match(r) = (r != 0) & ((use_rs & r == id_rs) | (use_rt & r == id_rt)):
  - Load-use: ex_MemRead & match(ex_dst).
  - Branch-EX: is_br & ex_RegWrite & match(ex_dst).
  - Branch-MEM: is_br & mem_MemRead & match(mem_dst).
  - stall = OR of the three.
- Stall effects:
  - pc_write = ifid_write = ~stall.
  - ifid_flush = id_IFIDFlush & ~stall. A stalled jump or branch re-decodes next cycle and flushes then.
- Each clk edge without reset:
  - If stall: all ex_* control outputs load 0 (bubble); data and field outputs load the current ID values.
  - Otherwise: every ex_* output loads its id_* input.
  - Shadow always advances: mem_dst <= ex_dst; mem_MemRead <= ex_MemRead. The bubble propagates into the shadow.
- Resulting stall lengths:
  - lw followed by a dependent ALU op, sw or lw: 1 stall cycle.
  - ALU op followed by a dependent beq/jr: 1 stall cycle.
  - lw followed by a dependent beq/jr: 2 stall cycles (load-use, then branch-MEM).
- Counters:
  - stall_cnt increments on every edge where stall = 1.
  - bubble_cnt increments on each bubble latched. It equals stall_cnt here and is kept separate for a later external freeze.
  - Both saturate at all-ones; no wrap.
- Latency: 1 cycle from ID to the ex_* outputs.
- No multi-cycle hold:
  - The hazard is re-evaluated every cycle.
  - Reset asserted mid-stall clears the EX and MEM state, so stall = 0 in the cycle after reset.

Test Plan:
- lw $8,0($0) then add $9,$8,$1 -> stall=1 for exactly one cycle, pc_write=0, one bubble (ex_RegWrite=0, ex_MemRead=0), then add latched with ex_dst=9; stall_cnt=1.
- lw $8 then beq $8,$2 -> stall for two consecutive cycles; ifid_flush=0 in both even with id_IFIDFlush=1; flush passes on the third cycle; stall_cnt=2.
- addi $5,$0,3 then jr $5 -> one stall cycle; the jr enters EX after it, with ex_rs=5.
- lw $0,4($0) then add $3,$0,$0 -> no stall (destination 0); addi $4 then j -> no stall (j uses no sources).
- jal with RegDst=10 -> ex_dst=31, ex_RegWrite=1. A following jr $31 stalls one cycle; a following add $2,$31,$1 does not stall.
- Force 2^CNT_W+3 stall cycles -> stall_cnt holds at all-ones. Assert rst mid-stall -> next cycle all ex_* = 0, counters = 0, pc_write=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use / ID-branch hazard detection
// A hazard zeroes the control bundle entering EX and freezes PC and IF/ID for that cycle.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        id_opc,
  input  logic [1:0]        id_RegDst,
  input  logic [1:0]        id_RegData,
  input  logic              id_ALUSrc,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_RegWrite,
  input  logic [2:0]        id_ALUOpc,
  input  logic              id_IFIDFlush,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic [1:0]        ex_RegData,
  output logic [2:0]        ex_ALUOpc,
  output logic              ex_ALUSrc,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_RegWrite,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_JR   = 6'b111111;

  logic       use_rs, use_rt, is_br;
  logic [4:0] id_dst;
  logic       hit_ex, hit_mem, stall;
  logic [4:0] mem_dst;
  logic       mem_MemRead;

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    is_br  = 1'b0;
    case (id_opc)
      OPC_R, OPC_SW, OPC_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OPC_ADDI, OPC_SLTI, OPC_LW, OPC_JR: use_rs = 1'b1;
      default: ;
    endcase
    if (id_opc == OPC_BEQ || id_opc == OPC_JR) is_br = 1'b1;
  end

  always_comb begin
    case (id_RegDst)
      2'b00:   id_dst = id_rt;
      2'b01:   id_dst = id_rd;
      2'b10:   id_dst = 5'd31;
      default: id_dst = 5'd0;
    endcase
  end

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  assign hit_ex  = (ex_dst != 5'd0) &
                   ((use_rs & (ex_dst == id_rs)) | (use_rt & (ex_dst == id_rt)));
  assign hit_mem = (mem_dst != 5'd0) &
                   ((use_rs & (mem_dst == id_rs)) | (use_rt & (mem_dst == id_rt)));

  assign stall = (ex_MemRead & hit_ex) |
                 (is_br & ex_RegWrite & hit_ex) |
                 (is_br & mem_MemRead & hit_mem);

  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign ifid_flush = id_IFIDFlush & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_RegData  <= '0;
      ex_ALUOpc   <= '0;
      ex_ALUSrc   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_pc4      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      mem_dst     <= '0;
      mem_MemRead <= 1'b0;
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
    end else begin
      mem_dst     <= ex_dst;
      mem_MemRead <= ex_MemRead;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_pc4      <= id_pc4;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_dst      <= id_dst;
      if (stall) begin
        ex_RegData  <= '0;
        ex_ALUOpc   <= '0;
        ex_ALUSrc   <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_RegWrite <= 1'b0;
        if (stall_cnt != '1)  stall_cnt  <= stall_cnt + 1'b1;
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
      end else begin
        ex_RegData  <= id_RegData;
        ex_ALUOpc   <= id_ALUOpc;
        ex_ALUSrc   <= id_ALUSrc;
        ex_MemRead  <= id_MemRead;
        ex_MemWrite <= id_MemWrite;
        ex_RegWrite <= id_RegWrite;
      end
    end
  end

endmodule
